// File: rtl/wb_dma_pkg.sv
// rtl/wb_dma_pkg.sv - shared types and widths for the DMA transfer-size counter
package wb_dma_pkg;

    localparam int DMA_SZW  = 12;
    localparam int DMA_CHKW = 9;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        CHK_WAIT = 2'd2
    } wb_dma_sz_state_t;

endpackage

// File: rtl/wb_dma_dec_sat.sv
// rtl/wb_dma_dec_sat.sv - registered down-counter with load, enable and ==1 flag
module wb_dma_dec_sat #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         is_one
);

    localparam logic [W-1:0] ONE = W'(1);

    // Stops at zero so a stray enable can never wrap the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - ONE;
        end
    end

    assign is_one = (cnt == ONE);

endmodule

// File: rtl/wb_dma_sz_dec.sv
// rtl/wb_dma_sz_dec.sv - per-channel transfer/chunk size down-counter and FSM
module wb_dma_sz_dec
    import wb_dma_pkg::*;
#(
    parameter int SZW  = DMA_SZW,
    parameter int CHKW = DMA_CHKW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ld,
    input  logic [SZW-1:0]  tot_sz_in,
    input  logic [CHKW-1:0] chk_sz_in,
    input  logic            dec,
    input  logic            resume,
    input  logic            abort,
    output logic [SZW-1:0]  tot_sz,
    output logic [CHKW-1:0] chk_cnt,
    output logic            busy,
    output logic            chk_wait,
    output logic            chunk_done,
    output logic            xfer_done
);

    wb_dma_sz_state_t state, state_nxt;
    logic [CHKW-1:0]  chk_sz_q;
    logic [CHKW-1:0]  chk_ld_val;
    logic             tot_ld, tot_en, chk_ld, chk_en, store_chk;
    logic             tot_one, chk_one;
    logic             xfer_nxt, chunk_nxt;
    logic             chunked;

    assign chunked  = (chk_sz_q != '0);
    assign busy     = (state != IDLE);
    assign chk_wait = (state == CHK_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else if (ld) begin
            state_nxt = (tot_sz_in != '0) ? RUN : IDLE;
        end else begin
            case (state)
                RUN: begin
                    if (dec) begin
                        if (tot_one)                 state_nxt = IDLE;
                        else if (chunked && chk_one) state_nxt = CHK_WAIT;
                    end
                end
                CHK_WAIT: if (resume) state_nxt = RUN;
                IDLE:     state_nxt = IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    // The last word of the transfer wins over a coincident chunk boundary.
    always_comb begin
        tot_ld     = 1'b0;
        tot_en     = 1'b0;
        chk_ld     = 1'b0;
        chk_en     = 1'b0;
        store_chk  = 1'b0;
        chk_ld_val = chk_sz_q;
        xfer_nxt   = 1'b0;
        chunk_nxt  = 1'b0;
        if (!abort) begin
            if (ld) begin
                tot_ld = 1'b1;
                if (tot_sz_in != '0) begin
                    chk_ld     = 1'b1;
                    store_chk  = 1'b1;
                    chk_ld_val = chk_sz_in;
                end else begin
                    xfer_nxt = 1'b1;
                end
            end else if ((state == RUN) && dec) begin
                tot_en = 1'b1;
                if (tot_one) begin
                    xfer_nxt = 1'b1;
                    chk_en   = chunked;
                end else if (chunked && chk_one) begin
                    chk_ld    = 1'b1;
                    chunk_nxt = 1'b1;
                end else begin
                    chk_en = chunked;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_sz_q   <= '0;
            chunk_done <= 1'b0;
            xfer_done  <= 1'b0;
        end else begin
            if (store_chk) chk_sz_q <= chk_sz_in;
            chunk_done <= chunk_nxt;
            xfer_done  <= xfer_nxt;
        end
    end

    wb_dma_dec_sat #(.W(SZW)) u_tot (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld     (tot_ld),
        .ld_val (tot_sz_in),
        .en     (tot_en),
        .cnt    (tot_sz),
        .is_one (tot_one)
    );

    wb_dma_dec_sat #(.W(CHKW)) u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld     (chk_ld),
        .ld_val (chk_ld_val),
        .en     (chk_en),
        .cnt    (chk_cnt),
        .is_one (chk_one)
    );

endmodule

// File: tb/tb_wb_dma_sz_dec.sv
// tb/tb_wb_dma_sz_dec.sv - scoreboard bench for wb_dma_sz_dec
module tb_wb_dma_sz_dec;

    localparam int SZW  = 12;
    localparam int CHKW = 9;
    localparam int M_IDLE = 0, M_RUN = 1, M_WAIT = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ld = 1'b0;
    logic [SZW-1:0]  tot_sz_in = '0;
    logic [CHKW-1:0] chk_sz_in = '0;
    logic            dec = 1'b0;
    logic            resume = 1'b0;
    logic            abort = 1'b0;
    logic [SZW-1:0]  tot_sz;
    logic [CHKW-1:0] chk_cnt;
    logic            busy, chk_wait, chunk_done, xfer_done;

    typedef struct {
        int tot;
        int chk;
        int busy;
        int cw;
        int cd;
        int xd;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    int m_st  = M_IDLE;
    int m_tot = 0;
    int m_chk = 0;
    int m_csz = 0;

    wb_dma_sz_dec dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld         (ld),
        .tot_sz_in  (tot_sz_in),
        .chk_sz_in  (chk_sz_in),
        .dec        (dec),
        .resume     (resume),
        .abort      (abort),
        .tot_sz     (tot_sz),
        .chk_cnt    (chk_cnt),
        .busy       (busy),
        .chk_wait   (chk_wait),
        .chunk_done (chunk_done),
        .xfer_done  (xfer_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_out(input int cd, input int xd);
        exp_t e;
        e.tot  = m_tot;
        e.chk  = m_chk;
        e.busy = (m_st != M_IDLE) ? 1 : 0;
        e.cw   = (m_st == M_WAIT) ? 1 : 0;
        e.cd   = cd;
        e.xd   = xd;
        return e;
    endfunction

    // Reference behaviour: count a word off, then decide what the new count means.
    task automatic model_step(input bit l, input int t, input int c,
                              input bit d, input bit r, input bit a);
        int cd = 0;
        int xd = 0;
        if (a) begin
            m_st = M_IDLE;
        end else if (l) begin
            if (t != 0) begin
                m_tot = t; m_csz = c; m_chk = c; m_st = M_RUN;
            end else begin
                m_tot = 0; m_st = M_IDLE; xd = 1;
            end
        end else if (m_st == M_RUN && d) begin
            m_tot = m_tot - 1;
            if (m_csz != 0) m_chk = m_chk - 1;
            if (m_tot == 0) begin
                m_st = M_IDLE; xd = 1;
            end else if (m_csz != 0 && m_chk == 0) begin
                m_chk = m_csz; m_st = M_WAIT; cd = 1;
            end
        end else if (m_st == M_WAIT && r) begin
            m_st = M_RUN;
        end
        q.push_back(model_out(cd, xd));
    endtask

    task automatic cyc(input bit l, input int t, input int c,
                       input bit d, input bit r, input bit a);
        @(negedge clk);
        rst_n     = 1'b1;
        ld        = l;
        tot_sz_in = SZW'(t);
        chk_sz_in = CHKW'(c);
        dec       = d;
        resume    = r;
        abort     = a;
        model_step(l, t, c, d, r, a);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ld = 1'b0; dec = 1'b0; resume = 1'b0; abort = 1'b0;
        m_st = M_IDLE; m_tot = 0; m_chk = 0; m_csz = 0;
        #1;
        check("rst_tot_sz", int'(tot_sz), 0);
        check("rst_chk_cnt", int'(chk_cnt), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_xfer_done", int'(xfer_done), 0);
        q.push_back(model_out(0, 0));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("tot_sz", int'(tot_sz), e.tot);
                check("chk_cnt", int'(chk_cnt), e.chk);
                check("busy", int'(busy), e.busy);
                check("chk_wait", int'(chk_wait), e.cw);
                check("chunk_done", int'(chunk_done), e.cd);
                check("xfer_done", int'(xfer_done), e.xd);
                if (chunk_done && xfer_done) check("pulse_overlap", 1, 0);
            end
        end
    end

    property p_dec_step;
        @(posedge clk) disable iff (!rst_n)
            (busy && !chk_wait && dec && !ld && !abort) |=> (tot_sz == $past(tot_sz) - 12'd1);
    endproperty

    a_dec_step: assert property (p_dec_step) checks++;
        else begin
            errors++;
            $display("FAIL dec_step: got %0d expected one below previous", tot_sz);
        end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int guard;
        do_reset();
        cyc(0, 0, 0, 0, 0, 0);

        // basic transfer
        cyc(1, 5, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // chunked transfer, resume the cycle after each chunk_done
        cyc(1, 6, 2, 0, 0, 0);
        guard = 0;
        while (m_st != M_IDLE && guard < 30) begin
            cyc(0, 0, 0, 1, (m_st == M_WAIT), 0);
            guard++;
        end
        check("chunk_xfer_ends", m_st, M_IDLE);

        // boundary loads
        cyc(1, 0, 3, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 4095, 0, 0, 0, 0);
        for (int i = 0; i < 4095; i++) cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);

        // abort beats ld and dec
        cyc(1, 5, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 7, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 7, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // asynchronous reset mid-transfer
        cyc(1, 4, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        do_reset();
        cyc(1, 2, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit l, d, r, a;
            int t, c;
            l = ($urandom_range(0, 15) == 0);
            t = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
            c = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 4));
            d = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 3);
            a = ($urandom_range(0, 31) == 0);
            if (m_st == M_IDLE && $urandom_range(0, 3) == 0) l = 1'b1;
            cyc(l, t, c, d, r, a);
        end

        cyc(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        check("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
